// File: rtl/t07_qspi_rx_engine_pkg.sv
// Shared types and helpers for the quad-SPI read engine: FSM state encoding,
// lane-count legality and the beats-per-word calculation.
package t07_qspi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DUMMY = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } qspi_state_t;

  localparam int LANES_SINGLE = 1;
  localparam int LANES_DUAL   = 2;
  localparam int LANES_QUAD   = 4;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == LANES_SINGLE) || (lanes == LANES_DUAL) || (lanes == LANES_QUAD);
  endfunction

  // Number of sclk beats needed to assemble one word.
  function automatic int beats(input int word_w, input int lanes);
    return word_w / lanes;
  endfunction

endpackage

// File: rtl/t07_qspi_rx_engine_fifo.sv
// First-word-fall-through FIFO buffering received words until MMIO pops them.
// The head reads as zero while empty so data_o has a defined idle value.
module t07_qspi_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             sclk_i,
  input  logic             nrst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sclk_i or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge sclk_i) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/t07_qspi_rx_engine.sv
// Quad-SPI burst read engine: chip-select, dummy cycles, LANES-wide shifting
// into words, and a clock gate that holds the slave whenever the FIFO is full.
module t07_qspi_rx_engine
  import t07_qspi_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                           sclk_i,
  input  logic                           nrst,
  input  logic                           start_i,
  input  logic [$clog2(MAX_BURST+1)-1:0] burst_len_i,
  input  logic [3:0]                     dummy_i,
  input  logic [LANES-1:0]               esp_data_i,
  input  logic                           pop_i,
  output logic                           cs_n_o,
  output logic                           sclk_en_o,
  output logic [WORD_W-1:0]              data_o,
  output logic                           valid_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int BEATS_N = beats(WORD_W, LANES);
  localparam int BEAT_W  = (BEATS_N > 1) ? $clog2(BEATS_N) : 1;
  localparam int LEN_W   = $clog2(MAX_BURST + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_N - 1);

  generate
    if (WORD_W % LANES != 0) begin : g_chk_word_w
      $error("WORD_W must be a multiple of LANES");
    end
    if (!lanes_legal(LANES)) begin : g_chk_lanes
      $error("LANES must be 1, 2 or 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of two of at least 2");
    end
  endgenerate

  qspi_state_t              state_q, state_d;
  logic [3:0]               dummy_q, dummy_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [LEN_W-1:0]         words_q, words_d;
  logic [WORD_W-LANES-1:0]  sr_q, sr_d;
  logic                     cs_n_q, cs_n_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     fifo_full, fifo_empty;
  logic                     stall, capture, last_beat, push;
  logic [WORD_W-1:0]        shift_word;

  // The full check only happens at a word boundary; once a word has started
  // nothing else pushes, so the FIFO cannot become full before it completes.
  assign stall      = (state_q == SHIFT) && (beat_q == '0) && fifo_full;
  assign capture    = (state_q == SHIFT) && !stall;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign push       = capture && last_beat;
  assign shift_word = {sr_q, esp_data_i};

  always_comb begin
    state_d = state_q;
    dummy_d = dummy_q;
    beat_d  = beat_q;
    words_d = words_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (burst_len_i == '0) begin
            state_d = DONE;
          end else begin
            // Oversized requests are clamped to the largest supported burst.
            words_d = (burst_len_i > MAX_LEN) ? MAX_LEN : burst_len_i;
            dummy_d = dummy_i;
            beat_d  = '0;
            state_d = (dummy_i == 4'd0) ? SHIFT : DUMMY;
          end
        end
      end
      DUMMY: begin
        dummy_d = dummy_q - 4'd1;
        if (dummy_q <= 4'd1) state_d = SHIFT;
      end
      SHIFT: begin
        if (capture) begin
          sr_d = shift_word[WORD_W-LANES-1:0];
          if (last_beat) begin
            beat_d  = '0;
            words_d = words_q - LEN_W'(1);
            if (words_q <= LEN_W'(1)) state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cs_n_d = !((state_d == DUMMY) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge sclk_i or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      dummy_q <= '0;
      beat_q  <= '0;
      words_q <= '0;
      sr_q    <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dummy_q <= dummy_d;
      beat_q  <= beat_d;
      words_q <= words_d;
      sr_q    <= sr_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  t07_qspi_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sclk_i  (sclk_i),
    .nrst    (nrst),
    .push_i  (push),
    .pop_i   (pop_i),
    .din_i   (shift_word),
    .dout_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign valid_o   = !fifo_empty;
  assign sclk_en_o = (state_q == DUMMY) || capture;

endmodule

// File: tb/tb_t07_qspi_rx_engine.sv
// Directed bench for the quad-SPI read engine: a table of single/double-word
// bursts checked cycle by cycle, plus stall, busy-start, reset and 1-lane cases.
module tb_t07_qspi_rx_engine;

  logic        sclk_i = 1'b0;
  logic        nrst   = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  burst_len_i = '0;
  logic [3:0]  dummy_i = '0;
  logic [3:0]  esp_data_i = '0;
  logic        pop_i = 1'b0;
  logic        cs_n_o, sclk_en_o, valid_o, busy_o, done_o;
  logic [31:0] data_o;

  logic        start8 = 1'b0;
  logic [4:0]  blen8 = '0;
  logic [3:0]  dummy8 = '0;
  logic [0:0]  esp8 = '0;
  logic        pop8 = 1'b0;
  logic        cs8, en8, valid8, busy8, done8;
  logic [7:0]  data8;

  always #5 sclk_i = ~sclk_i;

  t07_qspi_rx_engine dut (
    .sclk_i(sclk_i), .nrst(nrst), .start_i(start_i), .burst_len_i(burst_len_i),
    .dummy_i(dummy_i), .esp_data_i(esp_data_i), .pop_i(pop_i), .cs_n_o(cs_n_o),
    .sclk_en_o(sclk_en_o), .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  t07_qspi_rx_engine #(.WORD_W(8), .LANES(1)) dut8 (
    .sclk_i(sclk_i), .nrst(nrst), .start_i(start8), .burst_len_i(blen8),
    .dummy_i(dummy8), .esp_data_i(esp8), .pop_i(pop8), .cs_n_o(cs8),
    .sclk_en_o(en8), .data_o(data8), .valid_o(valid8), .busy_o(busy8),
    .done_o(done8)
  );

  typedef struct {
    logic [3:0]  dummy;
    logic [4:0]  blen;
    logic [31:0] w0;
    logic [31:0] w1;
    int          done_edge;  // edge at which done_o is sampled high
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_words [8];
  int          nib_idx = 0;
  int          pop_idx = 0;
  int          done_cnt = 0;
  int          steps = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk_i);
    #1;
  endtask

  function automatic logic [3:0] nib(input int i);
    logic [31:0] w;
    if (i < 0 || i >= 64) return 4'($urandom);
    w = exp_words[i / 8];
    return w[31 - 4 * (i % 8) -: 4];
  endfunction

  // One gated-clock cycle: the slave only advances its data when clocked.
  task automatic step(input logic pop);
    logic en_b;
    esp_data_i = nib(nib_idx);
    pop_i = pop;
    en_b = sclk_en_o;
    if (pop && valid_o) begin
      if (pop_idx < 8) chk($sformatf("word%0d", pop_idx), data_o, exp_words[pop_idx]);
      pop_idx++;
    end
    tick();
    steps++;
    pop_i = 1'b0;
    if (en_b) nib_idx++;
    if (done_o) done_cnt++;
  endtask

  task automatic start(input logic [3:0] d, input logic [4:0] n);
    dummy_i = d;
    burst_len_i = n;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    nib_idx = 0;
    pop_idx = 0;
    done_cnt = 0;
    steps = 0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          d, nb;
    bit          act;
    logic [4:0]  exp_f, act_f;
    d   = int'(v.dummy);
    nb  = int'(v.blen) * 8;
    act = (v.blen != 0);
    exp_words[0] = v.w0;
    exp_words[1] = v.w1;
    dummy_i = v.dummy;
    burst_len_i = v.blen;
    start_i = 1'b1;
    esp_data_i = 4'($urandom);
    tick();
    start_i = 1'b0;
    burst_len_i = 5'($urandom);
    dummy_i = 4'($urandom);
    for (int k = 0; k <= v.done_edge + 1; k++) begin
      exp_f = {k == v.done_edge - 1, !(act && k < v.done_edge - 1), k < v.done_edge,
               act && k < d + nb, act && k >= d + 8};
      act_f = {done_o, cs_n_o, busy_o, sclk_en_o, valid_o};
      chk($sformatf("vec%0d edge%0d flags{done,cs_n,busy,en,valid}", id, k),
          32'(act_f), 32'(exp_f));
      esp_data_i = ((k - d) >= 0 && (k - d) < nb) ? nib(k - d) : 4'($urandom);
      tick();
    end
    for (int w = 0; w < int'(v.blen); w++) begin
      chk($sformatf("vec%0d valid before pop %0d", id, w), 32'(valid_o), 32'd1);
      chk($sformatf("vec%0d data %0d", id, w), data_o, exp_words[w]);
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    chk($sformatf("vec%0d drained valid", id), 32'(valid_o), 32'd0);
    chk($sformatf("vec%0d empty data", id), data_o, 32'd0);
    $display("vec %0d: dummy=%0d burst=%0d done_edge=%0d", id, d, v.blen, v.done_edge);
  endtask

  vec_t vecs [5];
  vec_t after_rst;
  logic [7:0] pat8;

  initial begin
    vecs[0] = '{4'd0,  5'd1, 32'h12345678, 32'h00000000, 9};
    vecs[1] = '{4'd3,  5'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 20};
    vecs[2] = '{4'd1,  5'd2, 32'hDEADBEEF, 32'h01234567, 18};
    vecs[3] = '{4'd15, 5'd1, 32'hFFFF0000, 32'h00000000, 24};
    vecs[4] = '{4'd0,  5'd0, 32'h00000000, 32'h00000000, 1};

    // Reset state
    tick();
    tick();
    chk("rst cs_n", 32'(cs_n_o), 32'd1);
    chk("rst sclk_en", 32'(sclk_en_o), 32'd0);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst data", data_o, 32'd0);
    chk("rst8 cs_n", 32'(cs8), 32'd1);
    #3 nrst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Back-pressure: six words into a four-deep FIFO with no pops
    exp_words[0] = 32'h11111111; exp_words[1] = 32'h2222BEEF; exp_words[2] = 32'h3C3C3C3C;
    exp_words[3] = 32'h89ABCDEF; exp_words[4] = 32'h0F0F1234; exp_words[5] = 32'h76543210;
    start(4'd0, 5'd6);
    repeat (31) step(1'b0);
    chk("stall en before 4th word done", 32'(sclk_en_o), 32'd1);
    step(1'b0);
    chk("stall en at full", 32'(sclk_en_o), 32'd0);
    chk("stall cs_n low", 32'(cs_n_o), 32'd0);
    chk("stall busy", 32'(busy_o), 32'd1);
    repeat (3) step(1'b0);
    chk("stall holds en", 32'(sclk_en_o), 32'd0);
    chk("stall beats", 32'(nib_idx), 32'd32);
    step(1'b1);
    repeat (12) step(1'b0);
    chk("one word after pop", 32'(nib_idx), 32'd40);
    chk("restalled en", 32'(sclk_en_o), 32'd0);
    for (int b = 0; b < 40 && pop_idx < 6; b++) step(1'b1);
    repeat (3) step(1'b0);
    chk("stall words popped", 32'(pop_idx), 32'd6);
    chk("stall done pulses", 32'(done_cnt), 32'd1);
    chk("stall end busy", 32'(busy_o), 32'd0);
    chk("stall end valid", 32'(valid_o), 32'd0);
    $display("stall burst: 6 words, popped=%0d", pop_idx);

    // start_i while busy must not restart or extend the burst
    exp_words[0] = 32'hCAFEBABE; exp_words[1] = 32'h13579BDF;
    start(4'd0, 5'd2);
    repeat (4) step(1'b0);
    start_i = 1'b1;
    burst_len_i = 5'd5;
    step(1'b0);
    start_i = 1'b0;
    for (int b = 0; b < 40 && done_cnt == 0; b++) step(1'b0);
    chk("busy start done edge", 32'(steps), 32'd16);
    for (int b = 0; b < 6; b++) step(1'b1);
    chk("busy start words", 32'(pop_idx), 32'd2);
    chk("busy start no restart", 32'(busy_o), 32'd0);
    $display("busy start: words=%0d", pop_idx);

    // Asynchronous reset in the middle of the second word
    exp_words[0] = 32'h01020304; exp_words[1] = 32'hA0B0C0D0; exp_words[2] = 32'h55AA55AA;
    start(4'd2, 5'd3);
    repeat (14) step(1'b0);
    chk("pre-reset valid", 32'(valid_o), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("mid rst cs_n", 32'(cs_n_o), 32'd1);
    chk("mid rst sclk_en", 32'(sclk_en_o), 32'd0);
    chk("mid rst valid", 32'(valid_o), 32'd0);
    chk("mid rst busy", 32'(busy_o), 32'd0);
    chk("mid rst done", 32'(done_o), 32'd0);
    chk("mid rst data", data_o, 32'd0);
    tick();
    #3 nrst = 1'b1;
    tick();
    $display("reset mid-burst applied");
    after_rst = '{4'd0, 5'd1, 32'hCAFEF00D, 32'h00000000, 9};
    run_vec(5, after_rst);

    // Single-lane, byte-wide build
    pat8 = 8'hC3;
    dummy8 = 4'd0;
    blen8 = 5'd1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      chk($sformatf("lane1 edge%0d valid", k), 32'(valid8), 32'(k >= 8));
      chk($sformatf("lane1 edge%0d done", k), 32'(done8), 32'(k == 8));
      if (k == 8) chk("lane1 data", 32'(data8), 32'h000000C3);
      esp8 = (k < 8) ? pat8[7 - k] : 1'($urandom);
      tick();
    end
    pop8 = 1'b1;
    tick();
    pop8 = 1'b0;
    chk("lane1 drained", 32'(valid8), 32'd0);
    $display("lane1: serial C3 received");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t07_qspi_rx_engine.md
# t07_qspi_rx_engine

Parametrised quad-SPI read engine; the team's MCU is master and the ESP32 is slave. A single `start_i` pulse from MMIO starts a burst of N words. The engine asserts chip-select, counts dummy cycles, then shifts `LANES` bits per `sclk_i` edge into `WORD_W`-bit words. Completed words go into a small FIFO that MMIO drains with `pop_i`. The slave clock is gated off whenever the FIFO cannot accept another word, so no data is ever lost.

## Interface
Parameters:
- `WORD_W`, default 32: bits per received word. Must be a multiple of `LANES`.
- `LANES`, default 4: data lanes. Legal values are 1, 2, 4.
- `FIFO_DEPTH`, default 4: words buffered. Must be a power of two, ≥ 2.
- `MAX_BURST`, default 16: largest burst length accepted.

Ports (clock and reset first):
- `sclk_i` in 1: engine clock. It is also the source of the clock sent to the ESP32.
- `nrst` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle start pulse from MMIO.
- `burst_len_i` in $clog2(MAX_BURST+1): number of words to read. Sampled only on start.
- `dummy_i` in 4: dummy cycles before data. Sampled only on start.
- `esp_data_i` in LANES: data lanes from the ESP32.
- `pop_i` in 1: MMIO consumes `data_o`.
- `cs_n_o` out 1: chip-select to the ESP32, active-low.
- `sclk_en_o` out 1: clock-gate enable for the ESP32 clock.
- `data_o` out WORD_W: FIFO head, first-word-fall-through.
- `valid_o` out 1: FIFO non-empty.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse at the end of a burst.

## Operation
- States: IDLE, DUMMY, SHIFT, DONE.
- **IDLE**
  - On `start_i` with `burst_len_i` ≠ 0: latch length and dummy count, clear the beat counter. Go to DUMMY, or straight to SHIFT if `dummy_i` = 0.
  - On `start_i` with `burst_len_i` = 0: go to DONE. `cs_n_o` is never asserted.
- **DUMMY**: decrement the dummy counter each cycle. Leave for SHIFT on the cycle the counter reaches 0.
- **SHIFT**
  - Beat counter runs 0..BEATS-1, where BEATS = WORD_W/LANES.
  - Every enabled cycle: shift register becomes {sr[WORD_W-LANES-1:0], esp_data_i}. Data is MSB-first and lane 3 is the MSB of each nibble.
  - On the last beat, the full word is pushed to the FIFO and the words-remaining count decrements.
  - After the last word: go to DONE.
- **Stall**: in SHIFT with beat = 0 and FIFO full, `sclk_en_o` = 0. No capture happens and no counters move. `cs_n_o` stays low. The full check ignores a same-cycle `pop_i`.
- **DONE**: `cs_n_o` = 1 and `done_o` = 1 for exactly one cycle, then IDLE.
- `start_i` is ignored while `busy_o` = 1.
- FIFO behaviour:
  - A pop when empty is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - A push never occurs when full, because the stall rule above prevents it.
  - Words remaining in the FIFO after `done_o` stay readable.
- Reset, including mid-burst: state IDLE, all counters 0, FIFO emptied.

## Timing
- Reset values: `cs_n_o` = 1; `sclk_en_o`, `valid_o`, `busy_o`, `done_o` = 0; `data_o` = 0.
- `cs_n_o`, `busy_o` and `done_o` are registered. `sclk_en_o` = (DUMMY) or (SHIFT and not stalled), decoded from registered state.
- `start_i` is sampled at edge E0. `cs_n_o` falls after E0.
- `esp_data_i` is sampled on rising edges E(1+dummy) through E(dummy+BEATS) for the first word.
- `valid_o` rises after edge E(dummy+BEATS), i.e. 4 + 8 = 12 edges for dummy = 4 with the default parameters.
- Unstalled burst of N words: `done_o` is high in cycle E(dummy + N·BEATS + 1).
- Every stall cycle adds exactly one cycle to all later events.

## Structure
- Package `t07_qspi_pkg` holds:
  - the state enum `qspi_state_t` (IDLE, DUMMY, SHIFT, DONE);
  - lane-count legality constants;
  - a `BEATS` helper function.
- Sub-module `t07_qspi_fifo` (parameters WIDTH, DEPTH): synchronous FWFT FIFO with push/pop/full/empty on `sclk_i` and `nrst`.
- Top level holds the FSM, counters and shift register.
- Elaboration-time assertion: WORD_W % LANES == 0.

## Test plan
- Defaults, dummy = 0, burst = 1, lanes drive nibbles 1,2,…,8 → `data_o` = 32'h12345678, `valid_o` after 8 edges, `done_o` on edge 9, `cs_n_o` high in DONE.
- Dummy = 3, burst = 2 → first capture at edge 4; words 32'hA5A5A5A5 and 32'h5A5A5A5A in order; `done_o` on edge 20.
- Burst = 6, no pops → `sclk_en_o` drops after 4 words with `cs_n_o` still low. Pop one word → exactly one more word is captured. Drain all → 6 words in order, then `done_o`.
- `burst_len_i` = 0 → `done_o` the cycle after start, `cs_n_o` stays 1. A `start_i` during a busy burst has no effect on the word count.
- `nrst` pulsed mid-word in burst 3 → all outputs return to reset values immediately and FIFO is empty. A new start then runs normally.
- LANES = 1, WORD_W = 8 build, serial 8'hC3 → `data_o` = 8'hC3 after 8 edges.
